// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the FC forward engine.
//   DATA_W    - memory / cell data width (Q8.8 by default)
//   FRAC_BITS - fractional bits of the cell format
//   ACC_W     - signed MAC accumulator width
//   fc_state_e - forward-pass sequencer states
//   sat16     - clamp a signed value into the 16-bit cell range
package fc_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC1,
    WB1,
    MAC2,
    WB2,
    DONE
  } fc_state_e;

  // Input is already scaled; callers sign-extend to 64 bits.
  function automatic logic [DATA_W-1:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)
      return 16'h7fff;
    else if (v < -64'sd32768)
      return 16'h8000;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// fc_mac_unit: signed multiply-accumulate shared by both FC layers.
//   clk, reset_n      - clock, asynchronous active-low reset
//   a, b              - 16-bit signed operands (weight, cell)
//   valid             - a/b carry a product to accumulate this cycle
//   last              - this product closes the current neuron
//   clear             - discard any partial sum; next valid starts fresh
//   result            - sat16(acc >>> FRAC_BITS) of the closed neuron
//   result_valid      - one-cycle pulse, result updated
module fc_mac_unit import fc_pkg::*; #(
  parameter int ACC_W     = fc_pkg::ACC_W,
  parameter int FRAC_BITS = fc_pkg::FRAC_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              valid,
  input  logic              last,
  input  logic              clear,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sum;
  logic signed [63:0]         scaled;
  logic                       fresh;

  // After a neuron closes, the next product reloads the accumulator
  // instead of adding, so neurons stream back to back with no bubble.
  always_comb begin
    prod   = 32'(signed'(a)) * 32'(signed'(b));
    sum    = fresh ? ACC_W'(prod) : acc + ACC_W'(prod);
    scaled = 64'(sum) >>> FRAC_BITS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      fresh        <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clear) begin
        fresh <= 1'b1;
      end else if (valid) begin
        acc   <= sum;
        fresh <= last;
        if (last) begin
          result       <= sat16(scaled);
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fc_fwd_engine.sv
// fc_fwd_engine: forward pass over the three-bank FC memory.
//   Loads x from bank0, computes FC1 into bank1 (h), FC2 into bank2 (y).
//   Option macro FC_RELU_EN: rectify hidden cells (h) before use/writeback.
// Ports:
//   clk, reset_n              - clock, asynchronous active-low reset
//   start                     - one-cycle pulse, begins a pass (ignored when busy)
//   mem_rdata                 - memory read data, valid the cycle after mem_addr
//   mem_we, mem_addr, mem_data - memory write enable / address / write data
//   fc1_com_end, fc2_com_end  - bank select {fc1,fc2}: 00 b0, 10 b1, 11 b2
//   busy                      - pass in progress
//   done                      - one-cycle completion pulse
module fc_fwd_engine import fc_pkg::*; #(
  parameter int FRT_CELL  = 32,
  parameter int MID_CELL  = 20,
  parameter int BCK_CELL  = 10,
  parameter int FRAC_BITS = fc_pkg::FRAC_BITS,
  parameter int ACC_W     = fc_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              fc1_com_end,
  output logic              fc2_com_end,
  output logic              busy,
  output logic              done
);

  localparam int MAX_CELL = (FRT_CELL > MID_CELL) ?
                            ((FRT_CELL > BCK_CELL) ? FRT_CELL : BCK_CELL) :
                            ((MID_CELL > BCK_CELL) ? MID_CELL : BCK_CELL);
  localparam int IW = $clog2(MAX_CELL);
  localparam int XW = $clog2(FRT_CELL);
  localparam int HW = $clog2(MID_CELL);
  localparam int YW = $clog2(BCK_CELL);

  localparam logic [15:0] LOAD_END = 16'(FRT_CELL - 1);
  localparam logic [15:0] MAC1_END = 16'(FRT_CELL + MID_CELL * FRT_CELL - 1);
  localparam logic [15:0] MAC2_END = 16'(MID_CELL + BCK_CELL * MID_CELL - 1);
  localparam logic [15:0] FRT_BASE = 16'(FRT_CELL);
  localparam logic [15:0] MID_BASE = 16'(MID_CELL);
  localparam logic [15:0] MID_LAST = 16'(MID_CELL - 1);
  localparam logic [15:0] BCK_LAST = 16'(BCK_CELL - 1);
  localparam logic [IW-1:0] FRT_LAST_I = IW'(FRT_CELL - 1);
  localparam logic [IW-1:0] MID_LAST_I = IW'(MID_CELL - 1);

  fc_state_e state, state_n;

  logic [15:0]       cnt_q;        // issue / writeback address
  logic [IW-1:0]     idx_q;        // operand index of the issued read
  logic              drain_q;      // last read issued, waiting for its data
  logic              rd_valid_q;   // mem_rdata carries a requested word
  logic [IW-1:0]     rd_idx_q;
  logic              rd_last_q;
  logic [IW-1:0]     out_idx_q;    // next neuron result slot
  logic              fc1_q, fc2_q;

  logic              issue, issue_last;
  logic [IW-1:0]     idx_last;
  logic [15:0]       issue_end;

  logic [DATA_W-1:0] xbuf [FRT_CELL];
  logic [DATA_W-1:0] hbuf [MID_CELL];
  logic [DATA_W-1:0] ybuf [BCK_CELL];

  logic [DATA_W-1:0] mac_b, mac_result, h_act;
  logic              mac_valid;

  assign fc1_com_end = fc1_q;
  assign fc2_com_end = fc2_q;

  // Sequencer: outputs are decoded from registered state and counters.
  always_comb begin
    state_n    = state;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    busy       = 1'b1;
    done       = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    idx_last   = FRT_LAST_I;
    issue_end  = LOAD_END;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        if (drain_q) state_n = MAC1;
        else begin
          issue    = 1'b1;
          mem_addr = cnt_q;
        end
      end
      MAC1: begin
        issue_end = MAC1_END;
        if (drain_q) state_n = WB1;
        else begin
          issue      = 1'b1;
          issue_last = (idx_q == idx_last);
          mem_addr   = cnt_q;
        end
      end
      WB1: begin
        mem_we   = 1'b1;
        mem_addr = cnt_q;
        mem_data = hbuf[cnt_q[HW-1:0]];
        if (cnt_q == MID_LAST) state_n = MAC2;
      end
      MAC2: begin
        idx_last  = MID_LAST_I;
        issue_end = MAC2_END;
        if (drain_q) state_n = WB2;
        else begin
          issue      = 1'b1;
          issue_last = (idx_q == idx_last);
          mem_addr   = cnt_q;
        end
      end
      WB2: begin
        mem_we   = 1'b1;
        mem_addr = cnt_q;
        mem_data = ybuf[cnt_q[YW-1:0]];
        if (cnt_q == BCK_LAST) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Weight addresses are contiguous per layer, so one running address
  // counter walks i-major/j-minor while idx_q wraps per neuron.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      drain_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_last_q  <= 1'b0;
      out_idx_q  <= '0;
      fc1_q      <= 1'b0;
      fc2_q      <= 1'b0;
    end else begin
      state      <= state_n;
      rd_valid_q <= issue;
      rd_idx_q   <= idx_q;
      rd_last_q  <= issue_last;
      if (issue) begin
        cnt_q <= cnt_q + 16'd1;
        idx_q <= (idx_q == idx_last) ? '0 : idx_q + IW'(1);
        if (cnt_q == issue_end) drain_q <= 1'b1;
      end else if (state == WB1 || state == WB2) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (mac_valid) out_idx_q <= out_idx_q + IW'(1);
      if (state_n != state) begin
        drain_q <= 1'b0;
        idx_q   <= '0;
        case (state_n)
          LOAD: begin cnt_q <= '0;       fc1_q <= 1'b0; fc2_q <= 1'b0; end
          MAC1: begin cnt_q <= FRT_BASE; out_idx_q <= '0; end
          WB1:  begin cnt_q <= '0;       fc1_q <= 1'b1; fc2_q <= 1'b0; end
          MAC2: begin cnt_q <= MID_BASE; out_idx_q <= '0; end
          WB2:  begin cnt_q <= '0;       fc1_q <= 1'b1; fc2_q <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mac_b = (state == MAC1) ? xbuf[rd_idx_q[XW-1:0]] : hbuf[rd_idx_q[HW-1:0]];
    h_act = mac_result;
`ifdef FC_RELU_EN
    if (mac_result[DATA_W-1]) h_act = '0;
`endif
  end

  fc_mac_unit #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk          (clk),
    .reset_n      (reset_n),
    .a            (mem_rdata),
    .b            (mac_b),
    .valid        (rd_valid_q && (state == MAC1 || state == MAC2)),
    .last         (rd_last_q),
    .clear        (state == IDLE),
    .result       (mac_result),
    .result_valid (mac_valid)
  );

  // The final neuron of each layer resolves in the first writeback cycle,
  // well before writeback reaches its slot.
  always_ff @(posedge clk) begin
    if (rd_valid_q && state == LOAD) xbuf[rd_idx_q[XW-1:0]] <= mem_rdata;
    if (mac_valid) begin
      if (state == MAC1 || state == WB1) hbuf[out_idx_q[HW-1:0]] <= h_act;
      else                               ybuf[out_idx_q[YW-1:0]] <= mac_result;
    end
  end

endmodule

// File: tb/tb_fc_fwd_engine.sv
// tb_fc_fwd_engine: scoreboard bench for fc_fwd_engine with a 1-cycle
// read-latency three-bank memory model and a fixed-point reference model.
module tb_fc_fwd_engine;

  localparam int FRT = 32;
  localparam int MID = 20;
  localparam int BCK = 10;
  localparam int LAT = FRT + MID * FRT + MID + BCK * MID + BCK + 4;

  typedef struct packed {
    logic [1:0]  bank;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        fc1_com_end, fc2_com_end, busy, done;

  logic [15:0] mem [0:3][0:1023];
  logic [15:0] addr_r = '0;
  logic [1:0]  bank_idx;
  wr_t         sb [$];
  wr_t         exp_w;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;

  fc_fwd_engine #(
    .FRT_CELL (FRT),
    .MID_CELL (MID),
    .BCK_CELL (BCK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .fc1_com_end (fc1_com_end),
    .fc2_com_end (fc2_com_end),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always_comb
    bank_idx = fc1_com_end ? (fc2_com_end ? 2'd2 : 2'd1) : (fc2_com_end ? 2'd3 : 2'd0);

  assign mem_rdata = mem[bank_idx][addr_r[9:0]];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory port: address registered, writes scored against the queue.
  always @(posedge clk) begin
    addr_r <= mem_addr;
    if (mem_we) begin
      wr_count++;
      check_eq("wr_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check_eq(exp_w.bank == 2'd1 ? "h_wr" : "y_wr",
                 64'({bank_idx, mem_addr, mem_data}), 64'(exp_w));
      end
    end
  end

  function automatic logic [15:0] sat_q(input longint s);
    longint v;
    v = s >>> 8;
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [15:0] rnd_small();
    return 16'($urandom_range(0, 1023)) - 16'd512;
  endfunction

  task automatic prepare(input int mode);
    logic [15:0] v;
    for (int j = 0; j < FRT; j++) begin
      case (mode)
        0:       v = 16'(j << 8);
        1:       v = 16'h7fff;
        2:       v = 16'h8000;
        3:       v = 16'h0100;
        default: v = rnd_small();
      endcase
      mem[0][10'(j)] = v;
    end
    for (int i = 0; i < MID; i++)
      for (int j = 0; j < FRT; j++) begin
        case (mode)
          0:       v = (i == j) ? 16'h0100 : 16'h0000;
          1, 2:    v = 16'h7fff;
          3:       v = 16'hff00;
          default: v = rnd_small();
        endcase
        mem[0][10'(FRT + i * FRT + j)] = v;
      end
    for (int k = 0; k < BCK; k++)
      for (int i = 0; i < MID; i++) begin
        if (mode == 4) v = rnd_small();
        else           v = (k == i) ? 16'h0100 : 16'h0000;
        mem[1][10'(MID + k * MID + i)] = v;
      end
  endtask

  task automatic push_expected();
    logic [15:0] h [0:MID-1];
    longint      s;
    for (int i = 0; i < MID; i++) begin
      s = 0;
      for (int j = 0; j < FRT; j++)
        s += longint'($signed(mem[0][10'(j)])) *
             longint'($signed(mem[0][10'(FRT + i * FRT + j)]));
      h[5'(i)] = sat_q(s);
`ifdef FC_RELU_EN
      if (h[5'(i)][15]) h[5'(i)] = 16'h0000;
`endif
      sb.push_back('{bank: 2'd1, addr: 16'(i), data: h[5'(i)]});
    end
    for (int k = 0; k < BCK; k++) begin
      s = 0;
      for (int i = 0; i < MID; i++)
        s += longint'($signed(mem[1][10'(MID + k * MID + i)])) *
             longint'($signed(h[5'(i)]));
      sb.push_back('{bank: 2'd2, addr: 16'(k), data: sat_q(s)});
    end
  endtask

  // Latency = rising edges from the edge sampling start to the edge
  // sampling done high.
  task automatic run_pass(input int mode, input int extra_at, input int abort_at);
    int lat, dones;
    lat   = -1;
    dones = 0;
    prepare(mode);
    if (abort_at < 0) push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (lat < 0) lat = cyc + 1;
      end
      if (cyc == abort_at) begin
        check_eq("busy_pre_abort", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_outs", 64'({mem_we, mem_addr, mem_data, fc1_com_end,
                                    fc2_com_end, busy, done}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        break;
      end
      if (cyc == extra_at) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    if (abort_at < 0) begin
      check_eq("done_lat", 64'(lat), 64'(LAT));
      check_eq("done_cnt", 64'(dones), 64'd1);
      check_eq("sb_drained", 64'(sb.size()), 64'd0);
      check_eq("busy_end", 64'(busy), 64'd0);
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", 64'({mem_we, mem_addr, mem_data, fc1_com_end,
                              fc2_com_end, busy, done}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_eq("idle_no_we", 64'(wr_count), 64'd0);

    run_pass(0, -1, -1);   // identity
    run_pass(1, -1, -1);   // positive saturation
    run_pass(2, -1, -1);   // negative saturation
    run_pass(3, -1, -1);   // negative hidden cells (ReLU sensitive)
    run_pass(4, -1, -1);   // random small values, rounding
    run_pass(0, 50, -1);   // start while busy is ignored
    run_pass(0, -1, 300);  // reset in the middle of MAC1
    run_pass(0, -1, -1);   // full pass after the abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
